// File: rtl/fma16_sched.sv
// fma16_sched: round-robin front end that shares one combinational fma16 datapath
// between NREQ requesters, holding operands for EXEC_CYCLES before capturing the result.
module fma16_sched #(
    parameter int NREQ        = 2,
    parameter int EXEC_CYCLES = 1,
    localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNTW       = $clog2(EXEC_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    input  logic [16*NREQ-1:0]   req_z,
    input  logic [2*NREQ-1:0]    req_rm,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_result,
    output logic                 rsp_err,
    output logic [15:0]          fma_x,
    output logic [15:0]          fma_y,
    output logic [15:0]          fma_z,
    output logic                 fma_mul,
    output logic                 fma_add,
    output logic                 fma_negr,
    output logic                 fma_negz,
    output logic [1:0]           fma_rm,
    input  logic [15:0]          fma_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [15:0]     fma_x_q, fma_x_d, fma_y_q, fma_y_d, fma_z_q, fma_z_d;
    logic [1:0]      fma_rm_q, fma_rm_d;
    logic [3:0]      fma_ctl_q, fma_ctl_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic [2:0]      sel_op;
    logic [15:0]     sel_x, sel_y, sel_z;
    logic [1:0]      sel_rm;
    logic [4:0]      dec;

    // Returns {legal, mul, add, negr, negz}.
    function automatic logic [4:0] decode_op(input logic [2:0] op);
        case (op)
            3'b000:  decode_op = 5'b1_0100;
            3'b001:  decode_op = 5'b1_0101;
            3'b010:  decode_op = 5'b1_1000;
            3'b011:  decode_op = 5'b1_1100;
            3'b100:  decode_op = 5'b1_1101;
            3'b101:  decode_op = 5'b1_1110;
            3'b110:  decode_op = 5'b1_1111;
            default: decode_op = 5'b0_0000;
        endcase
    endfunction

    // Search upward from ptr+1; the nested constant loops keep every select static.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!grant_vld && req_valid[j] && ((int'(ptr_q) + k) % NREQ) == j) begin
                    grant_vld = 1'b1;
                    grant_idx = IDW'(j);
                end
            end
        end
    end

    always_comb begin
        sel_op    = '0;
        sel_x     = '0;
        sel_y     = '0;
        sel_z     = '0;
        sel_rm    = '0;
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant_idx == IDW'(j)) begin
                sel_op = req_op[3*j +: 3];
                sel_x  = req_x[16*j +: 16];
                sel_y  = req_y[16*j +: 16];
                sel_z  = req_z[16*j +: 16];
                sel_rm = req_rm[2*j +: 2];
            end
            req_ready[j] = (state_q == IDLE) && grant_vld && (grant_idx == IDW'(j));
        end
        dec = decode_op(sel_op);
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        fma_x_d      = fma_x_q;
        fma_y_d      = fma_y_q;
        fma_z_d      = fma_z_q;
        fma_rm_d     = fma_rm_q;
        fma_ctl_d    = fma_ctl_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    ptr_d    = grant_idx;
                    rsp_id_d = grant_idx;
                    if (dec[4]) begin
                        fma_x_d   = sel_x;
                        fma_y_d   = sel_y;
                        fma_z_d   = sel_z;
                        fma_rm_d  = sel_rm;
                        fma_ctl_d = dec[3:0];
                        cnt_d     = CNTW'(EXEC_CYCLES - 1);
                        state_d   = EXEC;
                    end else begin
                        // Illegal opcode answers with a canonical NaN and never touches fma_*.
                        rsp_result_d = 16'h7E00;
                        rsp_err_d    = 1'b1;
                        rsp_valid_d  = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    rsp_result_d = fma_result;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= IDW'(NREQ - 1);
            cnt_q        <= '0;
            fma_x_q      <= '0;
            fma_y_q      <= '0;
            fma_z_q      <= '0;
            fma_rm_q     <= '0;
            fma_ctl_q    <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            fma_x_q      <= fma_x_d;
            fma_y_q      <= fma_y_d;
            fma_z_q      <= fma_z_d;
            fma_rm_q     <= fma_rm_d;
            fma_ctl_q    <= fma_ctl_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign fma_x      = fma_x_q;
    assign fma_y      = fma_y_q;
    assign fma_z      = fma_z_q;
    assign fma_rm     = fma_rm_q;
    assign fma_mul    = fma_ctl_q[3];
    assign fma_add    = fma_ctl_q[2];
    assign fma_negr   = fma_ctl_q[1];
    assign fma_negz   = fma_ctl_q[0];
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_fma16_sched.sv
// Bench for fma16_sched: a real-valued fma16 model drives fma_result, a monitor
// predicts arbitration, latency and responses from a scoreboard queue.
module tb_fma16_sched;
    localparam int NREQ = 2;
    localparam int EXEC = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [3*NREQ-1:0]    req_op = '0;
    logic [16*NREQ-1:0]   req_x = '0;
    logic [16*NREQ-1:0]   req_y = '0;
    logic [16*NREQ-1:0]   req_z = '0;
    logic [2*NREQ-1:0]    req_rm = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [0:0]           rsp_id;
    logic [15:0]          rsp_result;
    logic                 rsp_err;
    logic [15:0]          fma_x, fma_y, fma_z;
    logic                 fma_mul, fma_add, fma_negr, fma_negz;
    logic [1:0]           fma_rm;
    logic [15:0]          fma_result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fma16_sched #(.NREQ(NREQ), .EXEC_CYCLES(EXEC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_rm(req_rm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
        .fma_mul(fma_mul), .fma_add(fma_add), .fma_negr(fma_negr), .fma_negz(fma_negz),
        .fma_rm(fma_rm), .fma_result(fma_result)
    );

    // {mul, add, negr, negz} per opcode; entry 7 is the illegal opcode.
    logic [3:0] ctl_tab [8] = '{4'b0100, 4'b0101, 4'b1000, 4'b1100,
                                4'b1101, 4'b1110, 4'b1111, 4'b0000};

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) m = real'(h[9:0]) * (2.0 ** (-24));
        else        m = real'(1024 + int'(h[9:0])) * (2.0 ** (e - 25));
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real v);
        real        a;
        int         e;
        logic       s;
        logic [9:0] man;
        s = (v < 0.0);
        a = s ? -v : v;
        if (a == 0.0) return {s, 15'h0};
        e = 15;
        for (int k = 0; k < 80 && a >= 2.0; k++) begin a = a / 2.0; e++; end
        for (int k = 0; k < 80 && a < 1.0; k++) begin a = a * 2.0; e--; end
        if (e >= 31) return {s, 5'h1f, 10'h0};
        if (e <= 0) return {s, 15'h0};
        man = 10'($rtoi((a - 1.0) * 1024.0));
        return {s, 5'(e), man};
    endfunction

    function automatic logic [15:0] fma_ref(input logic [3:0] ctl, input logic [15:0] x, y, z);
        real p, t;
        p = ctl[3] ? h2r(x) * h2r(y) : h2r(x);
        if (ctl[1]) p = -p;
        t = ctl[2] ? (ctl[0] ? -h2r(z) : h2r(z)) : 0.0;
        return r2h(p + t);
    endfunction

    assign fma_result = fma_ref({fma_mul, fma_add, fma_negr, fma_negz}, fma_x, fma_y, fma_z);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic [15:0] res;
        logic        err;
        int          due;
    } exp_t;

    typedef struct packed {
        logic [15:0] x, y, z;
        logic [1:0]  rm;
        logic [3:0]  ctl;
    } fma_t;

    exp_t sbq[$];
    fma_t lastf;
    int   mptr;
    bit   midle;

    // Monitor: operand hold check, arbitration prediction, then response check.
    always @(negedge clk) begin : mon
        logic [NREQ-1:0] exp_rdy;
        int              g;
        exp_t            e;
        logic [2:0]      op;
        if (reset) begin
            sbq.delete();
            mptr  = NREQ - 1;
            midle = 1'b1;
            lastf = '0;
        end else begin
            chk("fma_hold", 64'({fma_x, fma_y, fma_z, fma_rm, fma_mul, fma_add, fma_negr, fma_negz}),
                64'(lastf));
            g = -1;
            if (midle) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
                end
            end
            exp_rdy = (g >= 0) ? NREQ'(1) << g : '0;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (g >= 0) begin
                op    = req_op[3*g +: 3];
                mptr  = g;
                midle = 1'b0;
                e.id  = g;
                if (op == 3'b111) begin
                    e.res = 16'h7E00;
                    e.err = 1'b1;
                    e.due = cyc + 1;
                end else begin
                    e.res = fma_ref(ctl_tab[op], req_x[16*g +: 16], req_y[16*g +: 16], req_z[16*g +: 16]);
                    e.err = 1'b0;
                    e.due = cyc + EXEC + 1;
                    lastf = {req_x[16*g +: 16], req_y[16*g +: 16], req_z[16*g +: 16],
                             req_rm[2*g +: 2], ctl_tab[op]};
                end
                sbq.push_back(e);
            end
            if (sbq.size() == 0) begin
                chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
            end else begin
                chk("rsp_valid_timing", 64'(rsp_valid), 64'(cyc >= sbq[0].due));
                if (rsp_valid) begin
                    chk("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
                    chk("rsp_result", 64'(rsp_result), 64'(sbq[0].res));
                    chk("rsp_err", 64'(rsp_err), 64'(sbq[0].err));
                    if (rsp_ready) begin
                        void'(sbq.pop_front());
                        midle = 1'b1;
                    end
                end
            end
        end
    end

    task automatic present(input int i, input logic [2:0] op, input logic [15:0] x, y, z,
                           input logic [1:0] rm);
        req_op[3*i +: 3]  = op;
        req_x[16*i +: 16] = x;
        req_y[16*i +: 16] = y;
        req_z[16*i +: 16] = z;
        req_rm[2*i +: 2]  = rm;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_accept(input int i);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = req_ready[i];
        end
        chk("accept_timeout", 64'(got), 64'(1));
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic issue(input int i, input logic [2:0] op, input logic [15:0] x, y, z,
                         input logic [1:0] rm);
        present(i, op, x, y, z, rm);
        wait_accept(i);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = (sbq.size() == 0) && midle;
        end
        chk("idle_timeout", 64'(done), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic traffic(input int n0, input int n1, input int prob, input int rdy,
                           input bit allow_ill);
        int rem [NREQ];
        bit acc [NREQ];
        bit fin;
        rem[0] = n0;
        rem[1] = n1;
        fin = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) acc[i] = req_valid[i] & req_ready[i];
            @(posedge clk);
            #1;
            fin = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    rem[i]--;
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && rem[i] > 0 && $urandom_range(99) < prob)
                    present(i, 3'(allow_ill ? $urandom_range(7) : $urandom_range(6)),
                            16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom));
                if (rem[i] > 0 || req_valid[i]) fin = 1'b0;
            end
            rsp_ready = ($urandom_range(99) < rdy);
        end
        chk("traffic_done", 64'(rem[0] + rem[1]), 64'(0));
        rsp_ready = 1'b1;
        wait_idle();
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_id", 64'(rsp_id), 64'(0));
        chk("reset_rsp_result", 64'(rsp_result), 64'(0));
        chk("reset_rsp_err", 64'(rsp_err), 64'(0));
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_fma", 64'({fma_x, fma_y, fma_z, fma_rm, fma_mul, fma_add, fma_negr, fma_negz}), 64'(0));
        @(posedge clk);
        #1 rsp_ready = 1'b1;

        issue(0, 3'b101, 16'h3C00, 16'h4000, 16'h3C00, 2'b01);
        @(negedge clk);
        chk("fnmadd_ctl", 64'({fma_mul, fma_add, fma_negr, fma_negz}), 64'(4'b1110));
        wait_idle();

        for (int op = 0; op < 7; op++) begin
            issue(0, 3'(op), 16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom));
            @(negedge clk);
            chk("op_ctl", 64'({fma_mul, fma_add, fma_negr, fma_negz}), 64'(ctl_tab[op]));
            wait_idle();
        end
        issue(0, 3'b001, 16'h4000, 16'h1234, 16'h3C00, 2'b00);
        @(negedge clk);
        chk("fsub_negz", 64'(fma_negz), 64'(1));
        wait_idle();

        issue(1, 3'b111, 16'h1111, 16'h2222, 16'h3333, 2'b11);
        @(negedge clk);
        chk("illegal_valid", 64'(rsp_valid), 64'(1));
        chk("illegal_err", 64'(rsp_err), 64'(1));
        chk("illegal_result", 64'(rsp_result), 64'(16'h7E00));
        chk("illegal_id", 64'(rsp_id), 64'(1));
        wait_idle();

        traffic(2, 2, 100, 100, 1'b0);

        rsp_ready = 1'b0;
        issue(0, 3'b011, 16'h4200, 16'h3800, 16'hBC00, 2'b10);
        present(1, 3'b010, 16'h4400, 16'h4400, 16'h0000, 2'b00);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        chk("bp_rsp_timeout", 64'(got), 64'(1));
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_accept(1);
        wait_idle();

        issue(0, 3'b000, 16'h3C00, 16'h0000, 16'h4000, 2'b00);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        traffic(1, 1, 100, 100, 1'b0);

        traffic(20, 20, 60, 75, 1'b1);

        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
